fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue between the fetch stage and the decode stage. It buffers up to DEPTH fetched entries, each holding an instruction, its PC and PC+4, so that a decode stall does not immediately freeze fetch. It uses valid/ready handshakes on both sides. A branch flush discards every wrong-path entry.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- XLEN, 32, width of instruction, PC and PC+4 fields
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  discard all entries, driven by branch_taken
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  queue accepts an entry this cycle
- in_instruction  in  XLEN  fetched instruction
- in_PC  in  XLEN  PC of the instruction
- in_PC_plus4  in  XLEN  PC+4
- out_valid  out  1  head entry valid for decode
- out_ready  in  1  decode consumes the head this cycle
- out_instruction  out  XLEN  head instruction
- out_PC  out  XLEN  head PC
- out_PC_plus4  out  XLEN  head PC+4
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage is a circular buffer with read and write pointers of $clog2(DEPTH)+1 bits. The MSB is the wrap flag.
  - empty: pointers equal.
  - full: index bits equal and MSBs differ.
- in_ready = !full && !flush. This is combinational.
- out_valid = !empty && !flush (non-bypass case). out_* fields are the head entry when out_valid=1, else 0.
- Enqueue occurs when in_valid && in_ready. The entry is written at the write pointer, and the write pointer increments.
- Dequeue occurs when out_valid && out_ready. The read pointer increments.
- Simultaneous enqueue and dequeue: both pointers advance and count is unchanged.
- Full: in_ready=0 even if out_ready=1 in the same cycle. There is no pass-through when full.
- Empty: out_valid=0. out_ready is ignored.
- flush=1 has priority over everything:
  - No enqueue or dequeue that cycle.
  - Both pointers are set to 0 at the next edge.
  - count=0 next cycle.
  - The input entry presented during the flush cycle is dropped.
- Wrap-around: pointers increment modulo 2·DEPTH. There is no special case at the index wrap.
- Pointers and count are 0 at reset.
- Storage contents are cleared to 0 at reset. They are not cleared on flush.

## Timing
- Reset values while rst=1:
  - in_ready=1
  - out_valid=0
  - out_instruction, out_PC and out_PC_plus4 = 0
  - count=0
- Reset is asynchronous, so assertion mid-operation empties the queue immediately. The first enqueue is possible at the first rising edge after rst deasserts.
- Latency without bypass: an entry enqueued at edge N gives out_valid=1 in the cycle after edge N.
- Throughput: 1 entry/cycle sustained when 0 < count < DEPTH and both sides are active.
- count updates at the clock edge and reflects the state after that edge's transfer.
- The first post-flush enqueue is possible in the cycle after the flush cycle.

## Configuration
- FETCH_QUEUE_BYPASS_EN
  - Defined: when the queue is empty and flush=0:
    - out_valid = in_valid.
    - out_* come combinationally from in_*.
    - If out_ready=1, the entry is consumed directly. It is not written and count stays 0.
    - If out_ready=0, the entry is enqueued normally.
    - Zero-cycle latency when empty.
  - Undefined: no bypass path. Minimum latency is 1 cycle as above.

## Test plan
- Reset mid-fill: enqueue 2 entries, assert rst between edges -> count=0, out_valid=0, in_ready=1 immediately. After release, enqueue PC=0x100 -> out_PC=0x100 next cycle.
- Fill to full: DEPTH=4, out_ready=0, enqueue PCs 0x0,0x4,0x8,0xC -> count=4, in_ready=0. A 5th in_valid is not accepted. Then out_ready=1 -> outputs 0x0,0x4,0x8,0xC in order.
- Full with simultaneous dequeue: count=4, in_valid=1, out_ready=1 -> one dequeue, no enqueue, count=3.
- Wrap-around: stream 10 entries (PC 0x0..0x24), in_valid=1 and out_ready=1 after 2-entry prefill -> in-order output, count steady at 2, no loss or duplication across pointer wrap.
- Flush: count=3, flush=1 with in_valid=1 (PC=0x200) -> out_valid=0 and in_ready=0 that cycle. Next cycle count=0 and 0x200 is absent. Enqueue PC=0x300 -> it is the next head.
- Bypass (macro defined): empty, in_valid=1, PC=0x40, out_ready=1 -> out_valid=1 and out_PC=0x40 same cycle, count remains 0. Undefined -> out_valid=0 that cycle, 0x40 appears next cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue (DEPTH entries of {instruction, PC, PC+4}); optional FETCH_QUEUE_BYPASS_EN.
// Latency: 1 cycle enqueue-to-head (0 cycles when empty with FETCH_QUEUE_BYPASS_EN).
// Backpressure: in_ready drops when full or flushing; out_valid drops on empty or flush.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_instruction,
  input  logic [XLEN-1:0]          in_PC,
  input  logic [XLEN-1:0]          in_PC_plus4,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_instruction,
  output logic [XLEN-1:0]          out_PC,
  output logic [XLEN-1:0]          out_PC_plus4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;
  localparam int EW = 3 * XLEN;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];

  logic          empty, full, bypass, enq, deq;
  logic [EW-1:0] head;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
    in_ready = !full && !flush;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass   = empty && !flush && !rst;
`else
    bypass   = 1'b0;
`endif
    head     = mem_q[rd_ptr_q[IW-1:0]];

    out_valid       = bypass ? in_valid : (!empty && !flush);
    out_instruction = '0;
    out_PC          = '0;
    out_PC_plus4    = '0;
    if (out_valid) begin
      if (bypass) begin
        out_instruction = in_instruction;
        out_PC          = in_PC;
        out_PC_plus4    = in_PC_plus4;
      end else begin
        {out_instruction, out_PC, out_PC_plus4} = head;
      end
    end

    // A bypassed entry consumed this cycle is never written.
    enq = in_valid && in_ready && !(bypass && out_ready);
    deq = out_valid && out_ready && !bypass;
  end

  always_comb begin
    mem_d = mem_q;
    if (enq) begin
      mem_d[wr_ptr_q[IW-1:0]] = {in_instruction, in_PC, in_PC_plus4};
    end
    wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, enq};
    rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, deq};
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  assign count = wr_ptr_q - rd_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, XLEN=32); expectations follow FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instruction, in_PC, in_PC_plus4;
  logic [31:0] out_instruction, out_PC, out_PC_plus4;
  logic [2:0]  count;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_PC(in_PC), .in_PC_plus4(in_PC_plus4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_PC(out_PC), .out_PC_plus4(out_PC_plus4),
    .count(count)
  );

  // Inputs change at posedge+1; outputs are checked at posedge+2.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] pc);
    in_PC          = pc;
    in_PC_plus4    = pc + 32'd4;
    in_instruction = pc ^ 32'h1300_0013;
  endtask

  task automatic clear_queue();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; set_in(32'h0);
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if ({out_instruction, out_PC, out_PC_plus4} !== 96'h0) begin errors++; $display("FAIL reset_out_fields got=%h/%h/%h want=0", out_instruction, out_PC, out_PC_plus4); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
    step();
    rst = 1'b0;
    in_valid = 1'b1; set_in(32'hA0); step();
    set_in(32'hA4); step();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL midfill_count got=%0d want=2", count); end
    rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL async_rst_count got=%0d want=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_rst_in_ready got=%b want=1", in_ready); end
    step();
    rst = 1'b0;
    in_valid = 1'b1; set_in(32'h100); step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_PC !== 32'h100) begin errors++; $display("FAIL post_rst_head got=%b/%h want=1/00000100", out_valid, out_PC); end
    checks++; if (out_PC_plus4 !== 32'h104) begin errors++; $display("FAIL post_rst_pc4 got=%h want=00000104", out_PC_plus4); end
    clear_queue();
  endtask

  task automatic test_fill();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin set_in(32'(i * 4)); step(); end
    set_in(32'h10);
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d want=4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fifth_rejected count got=%0d want=4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_PC !== 32'(i * 4) || out_instruction !== (32'(i * 4) ^ 32'h1300_0013)) begin
        errors++; $display("FAIL drain_order[%0d] got=%b/%h/%h want=1/%h", i, out_valid, out_PC, out_instruction, 32'(i * 4));
      end
      step();
    end
    out_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL drained got count=%0d out_valid=%b want 0/0", count, out_valid); end
  endtask

  task automatic test_full_deq();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin set_in(32'(i * 4)); step(); end
    set_in(32'h50); out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL full_deq_hs got in_ready=%b out_valid=%b want 0/1", in_ready, out_valid); end
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_deq_count got=%0d want=3", count); end
    checks++; if (out_PC !== 32'h4) begin errors++; $display("FAIL full_deq_head got=%h want=00000004", out_PC); end
    clear_queue();
  endtask

  task automatic test_wrap();
    out_ready = 1'b0; in_valid = 1'b1;
    set_in(32'h0); step();
    set_in(32'h4); step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) set_in(32'((i + 2) * 4)); else in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_PC !== 32'(i * 4)) begin
        errors++; $display("FAIL wrap_order[%0d] got=%b/%h want=1/%h", i, out_valid, out_PC, 32'(i * 4));
      end
      if (i < 8) begin
        checks++;
        if (count !== 3'd2) begin errors++; $display("FAIL wrap_count[%0d] got=%0d want=2", i, count); end
      end
      step();
    end
    out_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL wrap_end got count=%0d out_valid=%b want 0/0", count, out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin set_in(32'h10 + 32'(i * 4)); step(); end
    flush = 1'b1; set_in(32'h200); out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL flush_cycle got out_valid=%b in_ready=%b want 0/0", out_valid, in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL post_flush got count=%0d out_valid=%b want 0/0", count, out_valid); end
    in_valid = 1'b1; set_in(32'h300); step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_PC !== 32'h300 || count !== 3'd1) begin errors++; $display("FAIL post_flush_head got=%b/%h count=%0d want=1/00000300 count=1", out_valid, out_PC, count); end
    clear_queue();
  endtask

  task automatic test_bypass();
    in_valid = 1'b1; set_in(32'h40); out_ready = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    checks++; if (out_valid !== 1'b1 || out_PC !== 32'h40) begin errors++; $display("FAIL bypass_same_cycle got=%b/%h want=1/00000040", out_valid, out_PC); end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bypass_consumed got count=%0d out_valid=%b want 0/0", count, out_valid); end
`else
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nobypass_same_cycle got=%b want=0", out_valid); end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_PC !== 32'h40 || count !== 3'd1) begin errors++; $display("FAIL nobypass_next got=%b/%h count=%0d want=1/00000040 count=1", out_valid, out_PC, count); end
`endif
    step();
    out_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL bypass_end_count got=%0d want=0", count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_deq();
    test_wrap();
    test_flush();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
